ov7670_capture: RTL and testbench

Camera-side writer for the RGB444 frame buffer. It samples the OV7670 parallel bus (vsync, href, 8-bit data) on the camera pixel clock and assembles byte pairs into 12-bit pixels. It writes those pixels to linear addresses 0..W*H-1, using the same address width as the VGA reader on the other buffer port. Capture only begins on a frame boundary, and each completed frame is reported with error status.

---
 rtl/ov7670_pkg.sv | 32 +++
 rtl/ov7670_pixel_pack.sv | 44 ++++
 rtl/ov7670_capture.sv | 146 ++++++++++++++
 tb/tb_ov7670_capture.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared types and resolution defaults for the OV7670 capture path
package ov7670_pkg;

    localparam int DEFAULT_WIDTH  = 640;
    localparam int DEFAULT_HEIGHT = 480;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        ACTIVE,
        DONE
    } state_t;

    typedef logic [11:0] pixel_t;

    function automatic logic [3:0] pix_r(input pixel_t p);
        return p[11:8];
    endfunction

    function automatic logic [3:0] pix_g(input pixel_t p);
        return p[7:4];
    endfunction

    function automatic logic [3:0] pix_b(input pixel_t p);
        return p[3:0];
    endfunction

    function automatic pixel_t pix_make(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/ov7670_pixel_pack.sv
// rtl/ov7670_pixel_pack.sv - pairs camera bytes into RGB444 pixels and issues the write strobe
module ov7670_pixel_pack
    import ov7670_pkg::*;
(
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       allow,
    input  logic       href_q,
    input  logic [7:0] d_q,
    output logic       pair_done,
    output logic       w_en,
    output pixel_t     w_data
);

    logic       phase;
    logic [3:0] r_q;

    // A pair completes on the second byte; a pair cut short by href or enable is dropped.
    assign pair_done = enable && href_q && phase;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= 1'b0;
            r_q    <= '0;
            w_en   <= 1'b0;
            w_data <= '0;
        end else begin
            w_en <= pair_done && allow;
            if (pair_done && allow) begin
                w_data <= pix_make(r_q, d_q[7:4], d_q[3:0]);
            end
            if (enable && href_q) begin
                phase <= ~phase;
                if (!phase) begin
                    r_q <= d_q[3:0];
                end
            end else begin
                phase <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 frame capture: frame FSM, line/address counters and status flags
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int RESOLUTION_WIDTH  = DEFAULT_WIDTH,
    parameter int RESOLUTION_HEIGHT = DEFAULT_HEIGHT,
    parameter int AW                = $clog2(RESOLUTION_WIDTH * RESOLUTION_HEIGHT) + 1
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          cap_en,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    d,
    output logic          w_clk,
    output logic          w_en,
    output logic [AW-1:0] w_addr,
    output logic [11:0]   w_data,
    output logic          frame_done,
    output logic          frame_ok,
    output logic          line_err,
    output logic          overflow
);

    localparam int NPIX = RESOLUTION_WIDTH * RESOLUTION_HEIGHT;
    localparam int BCW  = $clog2(2 * RESOLUTION_WIDTH + 2);
    localparam int LCW  = $clog2(RESOLUTION_HEIGHT + 2);

    logic           vsync_q, href_q, href_qq;
    logic [7:0]     d_q;
    state_t         state, state_nxt;
    logic [BCW-1:0] byte_cnt, byte_nxt;
    logic [LCW-1:0] lines, lines_nxt;
    logic           line_err_nxt, overflow_nxt, frame_ok_nxt;
    logic           start;
    logic           full;
    logic           pair_done;
    pixel_t         pix;

    assign w_clk      = pclk;
    assign frame_done = (state == DONE);
    assign full       = (w_addr == AW'(NPIX));
    assign w_data     = pix;

    ov7670_pixel_pack u_pack (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .enable    ((state == ACTIVE) && !vsync_q),
        .allow     (!full),
        .href_q    (href_q),
        .d_q       (d_q),
        .pair_done (pair_done),
        .w_en      (w_en),
        .w_data    (pix)
    );

    always_comb begin
        state_nxt    = state;
        byte_nxt     = byte_cnt;
        lines_nxt    = lines;
        line_err_nxt = line_err;
        overflow_nxt = overflow;
        frame_ok_nxt = frame_ok;
        start        = 1'b0;
        case (state)
            IDLE: begin
                if (cap_en && vsync_q) begin
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                if (!vsync_q) begin
                    state_nxt    = ACTIVE;
                    start        = 1'b1;
                    byte_nxt     = '0;
                    lines_nxt    = '0;
                    line_err_nxt = 1'b0;
                    overflow_nxt = 1'b0;
                end
            end
            ACTIVE: begin
                if (href_q && (byte_cnt != '1)) begin
                    byte_nxt = byte_cnt + 1'b1;
                end
                if (href_qq && !href_q) begin
                    byte_nxt = '0;
                    if (lines != '1) begin
                        lines_nxt = lines + 1'b1;
                    end
                    if (byte_cnt != BCW'(2 * RESOLUTION_WIDTH)) begin
                        line_err_nxt = 1'b1;
                    end
                end
                if (pair_done && full) begin
                    overflow_nxt = 1'b1;
                end
                // vsync_q was low on entry, so any high here is the closing rising edge.
                if (vsync_q) begin
                    state_nxt = DONE;
                    if (href_q) begin
                        line_err_nxt = 1'b1;
                    end
                    frame_ok_nxt = !line_err_nxt && !overflow_nxt &&
                                   (lines_nxt == LCW'(RESOLUTION_HEIGHT));
                end
            end
            DONE: begin
                state_nxt = cap_en ? SYNC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q  <= 1'b0;
            href_q   <= 1'b0;
            href_qq  <= 1'b0;
            d_q      <= '0;
            state    <= IDLE;
            byte_cnt <= '0;
            lines    <= '0;
            line_err <= 1'b0;
            overflow <= 1'b0;
            frame_ok <= 1'b0;
            w_addr   <= '0;
        end else begin
            vsync_q  <= vsync;
            href_q   <= href;
            href_qq  <= href_q;
            d_q      <= d;
            state    <= state_nxt;
            byte_cnt <= byte_nxt;
            lines    <= lines_nxt;
            line_err <= line_err_nxt;
            overflow <= overflow_nxt;
            frame_ok <= frame_ok_nxt;
            if (start) begin
                w_addr <= '0;
            end else if (w_en) begin
                w_addr <= w_addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - self-checking bench for ov7670_capture
module tb_ov7670_capture;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;
    localparam int AW   = $clog2(NPIX) + 1;

    logic          pclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cap_en = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic [7:0]    d = 8'h00;
    logic          w_clk, w_en, frame_done, frame_ok, line_err, overflow;
    logic [AW-1:0] w_addr;
    logic [11:0]   w_data;

    ov7670_capture #(
        .RESOLUTION_WIDTH  (W),
        .RESOLUTION_HEIGHT (H)
    ) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .cap_en     (cap_en),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .w_clk      (w_clk),
        .w_en       (w_en),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .line_err   (line_err),
        .overflow   (overflow)
    );

    always #5 pclk = ~pclk;

    int tests = 0;
    int fails = 0;

    int         wr_addr_q[$];
    int         wr_data_q[$];
    int         done_cnt;
    logic       ok_s, lerr_s, ovf_s;
    logic [7:0] sent_b[$];
    int         line_len[$];
    bit         line_abt[$];

    typedef struct {
        string nm;
        int    nl;
        int    len0, len1, len2;
        int    exp_wr;
        bit    exp_ok, exp_lerr, exp_ovf;
    } vec_t;

    vec_t vecs[7];

    always @(negedge pclk) begin
        if (w_en) begin
            wr_addr_q.push_back(int'(w_addr));
            wr_data_q.push_back(int'(w_data));
        end
        if (frame_done) begin
            done_cnt++;
            ok_s   = frame_ok;
            lerr_s = line_err;
            ovf_s  = overflow;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic clear_rec();
        wr_addr_q.delete();
        wr_data_q.delete();
        sent_b.delete();
        line_len.delete();
        line_abt.delete();
        done_cnt = 0;
        ok_s = 1'b0;
        lerr_s = 1'b0;
        ovf_s = 1'b0;
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) begin
            href = 1'b1;
            d = 8'($urandom);
            sent_b.push_back(d);
            tick();
        end
        href = 1'b0;
        d = 8'h00;
        line_len.push_back(n);
        line_abt.push_back(1'b0);
        tick();
        tick();
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (3) tick();
    endtask

    // Reference: pixels are consecutive byte pairs within each line, written in order
    // to addresses 0.. until the buffer is full; status follows from line lengths.
    task automatic check_frame(input string nm);
        int exp_d[$];
        int pairs = 0;
        int nl = 0;
        int k = 0;
        bit err = 1'b0;
        int n;
        foreach (line_len[i]) begin
            for (int p = 0; p < line_len[i] / 2; p++) begin
                pairs++;
                if (exp_d.size() < NPIX) begin
                    exp_d.push_back(int'({sent_b[k + 2*p][3:0], sent_b[k + 2*p + 1]}));
                end
            end
            k += line_len[i];
            if (line_abt[i]) err = 1'b1;
            else begin
                nl++;
                if (line_len[i] != 2 * W) err = 1'b1;
            end
        end
        check({nm, " write count"}, wr_data_q.size(), exp_d.size());
        n = (wr_data_q.size() < exp_d.size()) ? wr_data_q.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s addr[%0d]", nm, i), wr_addr_q[i], i);
            check($sformatf("%s data[%0d]", nm, i), wr_data_q[i], exp_d[i]);
        end
        check({nm, " frame_done count"}, done_cnt, 1);
        check({nm, " frame_ok"}, ok_s, (!err && pairs <= NPIX && nl == H));
        check({nm, " line_err"}, lerr_s, err);
        check({nm, " overflow"}, ovf_s, (pairs > NPIX));
    endtask

    function automatic vec_t mk(input string nm, input int nl, input int a, input int b, input int c,
                                input int wr, input bit ok, input bit le, input bit ov);
        vec_t v;
        v.nm = nm; v.nl = nl; v.len0 = a; v.len1 = b; v.len2 = c;
        v.exp_wr = wr; v.exp_ok = ok; v.exp_lerr = le; v.exp_ovf = ov;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk("clean",      2, 8, 8, 0, 8, 1, 0, 0);
        vecs[1] = mk("short line", 2, 8, 6, 0, 7, 0, 1, 0);
        vecs[2] = mk("overflow",   3, 8, 8, 8, 8, 0, 0, 1);
        vecs[3] = mk("odd line",   2, 8, 7, 0, 7, 0, 1, 0);
        vecs[4] = mk("one line",   1, 8, 0, 0, 4, 0, 0, 0);
        vecs[5] = mk("long lines", 2, 10, 8, 0, 8, 0, 1, 1);
        vecs[6] = mk("clean again",2, 8, 8, 0, 8, 1, 0, 0);
        clear_rec();

        repeat (3) tick();
        check("reset outputs", {w_en, w_addr, w_data, frame_done, frame_ok, line_err, overflow}, '0);
        check("w_clk follows pclk", w_clk, pclk);

        // Armed mid-frame: release while lines stream with vsync low.
        cap_en = 1'b1;
        rst_n = 1'b1;
        send_line(8);
        send_line(8);
        check("armed mid-frame writes", wr_data_q.size(), 0);
        vsync_pulse();
        check("armed mid-frame frame_done", done_cnt, 0);

        foreach (vecs[v]) begin
            clear_rec();
            send_line(vecs[v].len0);
            if (vecs[v].nl > 1) send_line(vecs[v].len1);
            if (vecs[v].nl > 2) send_line(vecs[v].len2);
            if (vecs[v].exp_ovf) check({vecs[v].nm, " w_addr held"}, w_addr, NPIX);
            vsync_pulse();
            check({vecs[v].nm, " table writes"}, wr_data_q.size(), vecs[v].exp_wr);
            check({vecs[v].nm, " table ok"}, ok_s, vecs[v].exp_ok);
            check({vecs[v].nm, " table line_err"}, lerr_s, vecs[v].exp_lerr);
            check({vecs[v].nm, " table overflow"}, ovf_s, vecs[v].exp_ovf);
            check_frame(vecs[v].nm);
        end

        // Latency: w_en is visible two edges after the second byte is captured.
        clear_rec();
        href = 1'b1; d = 8'h0A; sent_b.push_back(d); tick();
        d = 8'hBC; sent_b.push_back(d); tick();
        href = 1'b0; d = 8'h00;
        @(negedge pclk);
        check("latency early w_en", w_en, 1'b0);
        @(negedge pclk);
        check("latency w_en", w_en, 1'b1);
        check("latency w_data", w_data, 12'hABC);
        check("latency w_addr", w_addr, 0);
        line_len.push_back(2); line_abt.push_back(1'b0);
        tick(); tick();
        vsync_pulse();
        check_frame("latency frame");

        // Abort: vsync rises with href still high, the pending byte pair is dropped.
        clear_rec();
        send_line(8);
        for (int i = 0; i < 3; i++) begin
            href = 1'b1; d = 8'($urandom); sent_b.push_back(d); tick();
        end
        line_len.push_back(3); line_abt.push_back(1'b1);
        vsync = 1'b1; d = 8'($urandom); tick();
        href = 1'b0; d = 8'h00;
        repeat (2) tick();
        vsync = 1'b0;
        repeat (3) tick();
        check_frame("abort");

        // Randomised frames against the reference.
        for (int f = 0; f < 8; f++) begin
            int nl;
            clear_rec();
            nl = $urandom_range(1, 3);
            for (int l = 0; l < nl; l++) begin
                send_line(($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 2 * W);
            end
            vsync_pulse();
            check_frame($sformatf("random frame %0d", f));
        end

        // Reset mid-frame, then a clean frame from address 0.
        clear_rec();
        send_line(8);
        for (int i = 0; i < 4; i++) begin
            href = 1'b1; d = 8'($urandom); tick();
        end
        #2;
        check("pre-reset w_addr nonzero", (w_addr != 0), 1'b1);
        rst_n = 1'b0;
        #1;
        check("async reset outputs", {w_en, w_addr, w_data, frame_done, frame_ok, line_err, overflow}, '0);
        tick(); tick();
        rst_n = 1'b1;
        clear_rec();
        for (int i = 0; i < 4; i++) begin
            href = 1'b1; d = 8'($urandom); tick();
        end
        href = 1'b0; tick(); tick();
        send_line(8);
        check("post-reset writes before vsync", wr_data_q.size(), 0);
        vsync_pulse();
        check("post-reset frame_done", done_cnt, 0);
        clear_rec();
        send_line(8);
        send_line(8);
        vsync_pulse();
        check_frame("after reset");

        // Disarm during frame 1: it completes, frame 2 is ignored.
        clear_rec();
        send_line(8);
        cap_en = 1'b0;
        send_line(8);
        vsync_pulse();
        check_frame("disarm frame 1");
        clear_rec();
        send_line(8);
        send_line(8);
        vsync_pulse();
        check("disarm frame 2 writes", wr_data_q.size(), 0);
        check("disarm frame 2 frame_done", done_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
